// File: rtl/xoodyak_pkg.sv
// rtl/xoodyak_pkg.sv - shared types and constants for the Xoodyak host driver
package xoodyak_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_PREFETCH = 3'd2,
        ST_SEND     = 3'd3,
        ST_COLLECT  = 3'd4,
        ST_FIN      = 3'd5
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_STRAY   = 2'd3;

    localparam int HASH_BYTES = 32;
    localparam int BYTE_W     = 8;
    localparam int DIGEST_W   = HASH_BYTES * BYTE_W;
    localparam int LEN_W      = 12;
    localparam int ADDR_W     = 10;
    localparam int HCNT_W     = $clog2(HASH_BYTES + 1);

endpackage

// File: rtl/xoodyak_digest_collector.sv
// rtl/xoodyak_digest_collector.sv - digest shift register, byte count and idle timeout for COLLECT
module xoodyak_digest_collector
    import xoodyak_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic                core_valid_i,
    input  logic [BYTE_W-1:0]   core_hash_i,
    output logic [DIGEST_W-1:0] digest_o,
    output logic                full_o,
    output logic                timeout_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [DIGEST_W-1:0] digest_q, digest_d;
    logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    always_comb begin
        digest_d = digest_q;
        hcnt_d   = hcnt_q;
        tmr_d    = tmr_q;
        if (clear_i) begin
            digest_d = '0;
            hcnt_d   = '0;
            tmr_d    = '0;
        end else if (en_i) begin
            if (core_valid_i) begin
                digest_d = {digest_q[DIGEST_W-BYTE_W-1:0], core_hash_i};
                hcnt_d   = hcnt_q + HCNT_W'(1);
                tmr_d    = '0;
            end else begin
                tmr_d    = tmr_q + TMR_W'(1);
            end
        end
    end

    // Both fire in the cycle whose edge completes the condition, so FIN follows directly.
    assign full_o    = en_i && core_valid_i && (hcnt_q == HCNT_W'(HASH_BYTES - 1));
    assign timeout_o = en_i && !core_valid_i && (tmr_q == TMR_W'(TIMEOUT - 1));
    assign digest_o  = digest_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digest_q <= '0;
            hcnt_q   <= '0;
            tmr_q    <= '0;
        end else begin
            digest_q <= digest_d;
            hcnt_q   <= hcnt_d;
            tmr_q    <= tmr_d;
        end
    end

endmodule

// File: rtl/xoodyak_host_driver.sv
// rtl/xoodyak_host_driver.sv - streams a RAM message into the Xoodyak core and collects its digest
module xoodyak_host_driver
    import xoodyak_pkg::*;
#(
    parameter int MAX_LEN = 1024,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [LEN_W-1:0]    req_len_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic [BYTE_W-1:0]   mem_data_i,
    output logic                core_start_o,
    output logic [LEN_W-1:0]    core_msg_len_o,
    output logic [BYTE_W-1:0]   core_msg_o,
    input  logic                core_busy_i,
    input  logic [BYTE_W-1:0]   core_hash_i,
    input  logic                core_valid_i,
    output logic [DIGEST_W-1:0] digest_o,
    output logic                active_o,
    output logic                done_o,
    output logic [1:0]          err_o
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              stray_q, stray_d;
    logic [1:0]        err_q, err_d;
    logic              clear;
    logic              hash_full;
    logic              hash_timeout;

    xoodyak_digest_collector #(
        .TIMEOUT(TIMEOUT)
    ) u_collector (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear),
        .en_i        (state_q == ST_COLLECT),
        .core_valid_i(core_valid_i),
        .core_hash_i (core_hash_i),
        .digest_o    (digest_o),
        .full_o      (hash_full),
        .timeout_o   (hash_timeout)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        idx_d        = idx_q;
        stray_d      = stray_q;
        err_d        = err_q;
        clear        = 1'b0;
        core_start_o = 1'b0;
        mem_addr_o   = '0;
        core_msg_o   = '0;
        done_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    len_d   = req_len_i;
                    err_d   = ERR_OK;
                    stray_d = 1'b0;
                    if (req_len_i > LEN_W'(MAX_LEN)) begin
                        err_d   = ERR_LEN;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                core_start_o = 1'b1;
                clear        = 1'b1;
                idx_d        = '0;
                state_d      = (len_q != '0) ? ST_PREFETCH : ST_COLLECT;
            end
            ST_PREFETCH: state_d = ST_SEND;
            ST_SEND: begin
                // Addressing one ahead keeps the next byte ready after an accept; a stall re-reads idx.
                core_msg_o = mem_data_i;
                mem_addr_o = core_busy_i ? ADDR_W'(idx_q) : ADDR_W'(idx_q + IDX_W'(1));
                if (!core_busy_i) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(len_q - LEN_W'(1))) begin
                        state_d = ST_COLLECT;
                    end
                end
            end
            ST_COLLECT: begin
                if (hash_full) begin
                    err_d   = stray_q ? ERR_STRAY : ERR_OK;
                    state_d = ST_FIN;
                end else if (hash_timeout) begin
                    err_d   = stray_q ? ERR_STRAY : ERR_TIMEOUT;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (core_valid_i && (state_q inside {ST_START, ST_PREFETCH, ST_SEND})) begin
            stray_d = 1'b1;
        end
    end

    assign active_o       = state_q inside {ST_START, ST_PREFETCH, ST_SEND, ST_COLLECT};
    assign core_msg_len_o = len_q;
    assign err_o          = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            stray_q <= 1'b0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            stray_q <= stray_d;
            err_q   <= err_d;
        end
    end

endmodule
